// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: state encoding,
// grant encoding, default sizing and the round-robin pick.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CNT_W           = 8;

  // With both requesters pending, the one that did not win last time goes next.
  function automatic logic pick_grant(input logic i_pend,
                                      input logic d_pend,
                                      input logic last_grant);
    if (i_pend && d_pend) begin
      return ~last_grant;
    end else if (d_pend) begin
      return GRANT_D;
    end else begin
      return GRANT_I;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses the master view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              i_req;
  logic [DATA_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busywait;

  logic              err;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_done, i_busywait,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_done, d_busywait,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_busywait,
    output err
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_done, i_busywait,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_done, d_busywait,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_busywait,
    input  err
  );

endinterface

// File: rtl/mux_2x1_32bits.sv
// Plain 2:1 word multiplexer; sel=0 passes in0, sel=1 passes in1.
module mux_2x1_32bits #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_in0,
  input  logic [DATA_W-1:0] i_in1,
  input  logic              i_sel,
  output logic [DATA_W-1:0] o_out
);

  assign o_out = i_sel ? i_in1 : i_in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I, read-only)
// and data access (D, read/write), one transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic               CLK,
  input logic               RESET_N,
  mem_port_arbiter_if.slave bus
);

  // state      | meaning
  // ST_IDLE    | no transaction; arbitrate pending requests at next edge
  // ST_ACCESS  | strobe held, waiting for mem_busywait low or timeout
  // ST_RELEASE | one quiet cycle so the requester can drop/update its request

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t             r_state;
  logic               r_grant;
  logic               r_last_grant;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_i_done;
  logic               r_d_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;

  logic               w_i_pend;
  logic               w_d_pend;
  logic               w_next_grant;
  logic               w_d_wr_sel;
  logic               w_timeout;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [DATA_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;

  assign w_i_pend     = bus.i_req;
  assign w_d_pend     = bus.d_read | bus.d_write;
  assign w_next_grant = pick_grant(w_i_pend, w_d_pend, r_last_grant);
  // A D request with d_write set is a write regardless of d_read.
  assign w_d_wr_sel   = (w_next_grant == GRANT_D) && bus.d_write;
  assign w_cnt_next   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout    = (w_cnt_next >= TIMEOUT_CNT);

  mux_2x1_32bits #(.DATA_W(DATA_W)) u_addr_mux (
    .i_in0 (bus.i_addr),
    .i_in1 (bus.d_addr),
    .i_sel (r_grant),
    .o_out (w_mem_addr)
  );

  mux_2x1_32bits #(.DATA_W(DATA_W)) u_wdata_mux (
    .i_in0 ('0),
    .i_in1 (bus.d_wdata),
    .i_sel (r_grant),
    .o_out (w_mem_wdata)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_I;
      r_last_grant <= GRANT_I;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_i_pend || w_d_pend) begin
            r_grant     <= w_next_grant;
            r_mem_write <= w_d_wr_sel;
            r_mem_read  <= ~w_d_wr_sel;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (bus.mem_busywait) begin
            r_cnt <= w_cnt_next;
            // Aborted grantee still becomes last_grant so a stuck access
            // cannot starve the other requester.
            if (w_timeout) begin
              r_mem_read   <= 1'b0;
              r_mem_write  <= 1'b0;
              r_err        <= 1'b1;
              r_i_done     <= (r_grant == GRANT_I);
              r_d_done     <= (r_grant == GRANT_D);
              r_last_grant <= r_grant;
              r_state      <= ST_RELEASE;
            end
          end else begin
            if (r_mem_read && (r_grant == GRANT_I)) begin
              r_i_rdata <= bus.mem_rdata;
            end
            if (r_mem_read && (r_grant == GRANT_D)) begin
              r_d_rdata <= bus.mem_rdata;
            end
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_i_done     <= (r_grant == GRANT_I);
            r_d_done     <= (r_grant == GRANT_D);
            r_last_grant <= r_grant;
            r_state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.i_rdata    = r_i_rdata;
  assign bus.i_done     = r_i_done;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.d_done     = r_d_done;
  assign bus.err        = r_err;
  assign bus.i_busywait = bus.i_req & ~r_i_done;
  assign bus.d_busywait = (bus.d_read | bus.d_write) & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory with
// configurable wait states plus a transaction-level round-robin reference.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DW)) bus ();

  mem_port_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mem_wait_cfg = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_arr [logic [31:0]];
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  function automatic logic [31:0] fill_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : fill_word(a);
  endfunction

  // Memory: busy for mem_wait_cfg cycles of a strobe, then completes.
  initial begin : mem_resp
    bit active;
    int remaining;
    active = 1'b0;
    remaining = 0;
    bus.mem_busywait = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_read || bus.mem_write) begin
        if (!active) begin
          active = 1'b1;
          remaining = mem_wait_cfg;
        end else if (remaining > 0) begin
          remaining--;
        end
        bus.mem_busywait = (remaining > 0);
        if (remaining == 0) begin
          if (bus.mem_write) mem_arr[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr]
                                                            : fill_word(bus.mem_addr);
        end
      end else begin
        active = 1'b0;
        remaining = 0;
        bus.mem_busywait = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_done, bus.d_done, bus.err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.mem_read, bus.mem_write, bus.i_done, bus.d_done, bus.err});
    else n_pass++;
    n_checks++;
    if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0)
      $display("FAIL reset_rdata: got i=%h d=%h expected 0", bus.i_rdata, bus.d_rdata);
    else n_pass++;
    bus.i_req = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.mem_read !== 1'b0)
      $display("FAIL reset_hold_strobe: got %b expected 0", bus.mem_read);
    else n_pass++;
    bus.i_req = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i_read();
    int rd_cyc = 0, wr_cyc = 0, i_dn = 0, d_dn = 0, stall_bad = 0;
    logic busy_at_done = 1'b1;
    logic [31:0] addr_seen = '0, wdata_seen = '1;
    mem_arr[32'h100] = 32'hDEADBEEF;
    ref_arr[32'h100] = 32'hDEADBEEF;
    mem_wait_cfg = 3;
    bus.i_addr = 32'h100;
    bus.i_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_read) begin
        rd_cyc++;
        addr_seen = bus.mem_addr;
        wdata_seen = bus.mem_wdata;
        if (bus.i_busywait !== 1'b1) stall_bad++;
      end
      if (bus.mem_write) wr_cyc++;
      if (bus.d_done) d_dn++;
      if (bus.i_done) begin
        i_dn++;
        busy_at_done = bus.i_busywait;
        bus.i_req = 1'b0;
      end
    end
    exp_i_rdata = 32'hDEADBEEF;
    n_checks++;
    if (rd_cyc !== 4) $display("FAIL iread_strobe_len: got %0d expected 4", rd_cyc);
    else n_pass++;
    n_checks++;
    if (i_dn !== 1) $display("FAIL iread_done_cnt: got %0d expected 1", i_dn);
    else n_pass++;
    n_checks++;
    if (bus.i_rdata !== exp_i_rdata)
      $display("FAIL iread_rdata: got %h expected %h", bus.i_rdata, exp_i_rdata);
    else n_pass++;
    n_checks++;
    if (wr_cyc !== 0 || d_dn !== 0)
      $display("FAIL iread_d_idle: got wr=%0d d_done=%0d expected 0 0", wr_cyc, d_dn);
    else n_pass++;
    n_checks++;
    if (addr_seen !== 32'h100 || wdata_seen !== 32'h0)
      $display("FAIL iread_mux: got addr=%h wdata=%h expected 00000100 00000000",
               addr_seen, wdata_seen);
    else n_pass++;
    n_checks++;
    if (stall_bad !== 0 || busy_at_done !== 1'b0)
      $display("FAIL iread_busywait: got bad=%0d at_done=%b expected 0 0",
               stall_bad, busy_at_done);
    else n_pass++;
  endtask

  task automatic test_d_write();
    int rd_cyc = 0, wr_cyc = 0, d_dn = 0, i_dn = 0, done_at = -1;
    logic strobe_at_done = 1'b1;
    logic [31:0] addr_seen = '0, wdata_seen = '0;
    mem_wait_cfg = 0;
    bus.d_addr = 32'h10;
    bus.d_wdata = 32'h12345678;
    bus.d_write = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.mem_write) begin
        wr_cyc++;
        addr_seen = bus.mem_addr;
        wdata_seen = bus.mem_wdata;
      end
      if (bus.mem_read) rd_cyc++;
      if (bus.i_done) i_dn++;
      if (bus.d_done) begin
        d_dn++;
        if (done_at < 0) done_at = c;
        strobe_at_done = bus.mem_write | bus.mem_read;
        bus.d_write = 1'b0;
      end
    end
    ref_arr[32'h10] = 32'h12345678;
    n_checks++;
    if (wr_cyc !== 1 || rd_cyc !== 0)
      $display("FAIL dwrite_strobes: got wr=%0d rd=%0d expected 1 0", wr_cyc, rd_cyc);
    else n_pass++;
    n_checks++;
    if (addr_seen !== 32'h10 || wdata_seen !== 32'h12345678)
      $display("FAIL dwrite_mux: got addr=%h wdata=%h expected 00000010 12345678",
               addr_seen, wdata_seen);
    else n_pass++;
    n_checks++;
    if (d_dn !== 1 || i_dn !== 0 || done_at !== 2)
      $display("FAIL dwrite_done: got cnt=%0d i=%0d at=%0d expected 1 0 2", d_dn, i_dn, done_at);
    else n_pass++;
    n_checks++;
    if (strobe_at_done !== 1'b0)
      $display("FAIL dwrite_release: got strobe=%b expected 0", strobe_at_done);
    else n_pass++;
    n_checks++;
    if (mem_arr[32'h10] !== 32'h12345678)
      $display("FAIL dwrite_mem: got %h expected 12345678", mem_arr[32'h10]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int got[$];
    int at[$];
    int exp_seq[$];
    int last = 0;
    int bad_seq = 0, bad_gap = 0;
    logic [31:0] ia, da;
    apply_reset();
    mem_wait_cfg = 0;
    ia = 32'($urandom_range(0, 255)) << 2;
    da = (32'($urandom_range(0, 255)) << 2) | 32'h1000;
    for (int k = 0; k < 6; k++) begin
      last = (last == 0) ? 1 : 0;
      exp_seq.push_back(last);
    end
    bus.i_addr = ia;
    bus.d_addr = da;
    bus.i_req = 1'b1;
    bus.d_read = 1'b1;
    for (int c = 1; c <= 40 && got.size() < 6; c++) begin
      tick();
      if (bus.i_done) begin got.push_back(0); at.push_back(c); end
      if (bus.d_done) begin got.push_back(1); at.push_back(c); end
    end
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (got.size() !== 6) $display("FAIL rr_count: got %0d expected 6", got.size());
    else n_pass++;
    for (int k = 0; k < got.size() && k < 6; k++) begin
      if (got[k] != exp_seq[k]) bad_seq++;
      if (k > 0 && at[k] - at[k-1] != 3) bad_gap++;
    end
    n_checks++;
    if (bad_seq !== 0 || got.size() == 0 || at[0] !== 2)
      $display("FAIL rr_order: got %0d wrong grants, first done at %0d expected 0 at 2",
               bad_seq, (at.size() > 0) ? at[0] : -1);
    else n_pass++;
    n_checks++;
    if (bad_gap !== 0) $display("FAIL rr_gap: got %0d bad gaps expected 0", bad_gap);
    else n_pass++;
    exp_i_rdata = ref_rd(ia);
    exp_d_rdata = ref_rd(da);
    n_checks++;
    if (bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata)
      $display("FAIL rr_rdata: got i=%h d=%h expected i=%h d=%h",
               bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int rd_cyc = 0, err_cnt = 0, i_dn = 0, err_with_done = 0;
    logic strobe_after = 1'b1;
    mem_wait_cfg = 255;
    bus.i_addr = 32'h200;
    bus.i_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_read) rd_cyc++;
      if (bus.err) begin
        err_cnt++;
        if (bus.i_done) err_with_done++;
        strobe_after = bus.mem_read | bus.mem_write;
      end
      if (bus.i_done) begin
        i_dn++;
        bus.i_req = 1'b0;
      end
    end
    mem_wait_cfg = 0;
    n_checks++;
    if (rd_cyc !== TO) $display("FAIL timeout_len: got %0d expected %0d", rd_cyc, TO);
    else n_pass++;
    n_checks++;
    if (err_cnt !== 1 || err_with_done !== 1)
      $display("FAIL timeout_err: got err=%0d with_done=%0d expected 1 1", err_cnt, err_with_done);
    else n_pass++;
    n_checks++;
    if (i_dn !== 1 || strobe_after !== 1'b0)
      $display("FAIL timeout_done: got done=%0d strobe=%b expected 1 0", i_dn, strobe_after);
    else n_pass++;
    n_checks++;
    if (bus.i_rdata !== exp_i_rdata)
      $display("FAIL timeout_rdata: got %h expected %h", bus.i_rdata, exp_i_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int d_dn = 0, first_rd = -1, done_at = -1;
    logic was_active;
    mem_wait_cfg = 10;
    bus.d_addr = 32'h300;
    bus.d_read = 1'b1;
    tick();
    tick();
    tick();
    was_active = bus.mem_read;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (was_active !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0)
      $display("FAIL rstmid_strobe: got before=%b rd=%b wr=%b expected 1 0 0",
               was_active, bus.mem_read, bus.mem_write);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.d_done || bus.i_done) d_dn++;
    end
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    n_checks++;
    if (d_dn !== 0 || bus.d_rdata !== exp_d_rdata || bus.i_rdata !== exp_i_rdata)
      $display("FAIL rstmid_nodone: got done=%0d d=%h i=%h expected 0 0 0",
               d_dn, bus.d_rdata, bus.i_rdata);
    else n_pass++;
    mem_wait_cfg = 0;
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.mem_read && first_rd < 0) first_rd = c;
      if (bus.d_done) begin
        if (done_at < 0) done_at = c;
        bus.d_read = 1'b0;
      end
    end
    exp_d_rdata = ref_rd(32'h300);
    n_checks++;
    if (first_rd !== 1 || done_at !== 2)
      $display("FAIL rstmid_regrant: got strobe_at=%0d done_at=%0d expected 1 2", first_rd, done_at);
    else n_pass++;
    n_checks++;
    if (bus.d_rdata !== exp_d_rdata)
      $display("FAIL rstmid_rdata: got %h expected %h", bus.d_rdata, exp_d_rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    int last = 0;
    int err_total = 0;
    apply_reset();
    for (int r = 0; r < 30; r++) begin
      int mask, first, second, bad;
      int exp_seq[$];
      int got[$];
      bit dwr;
      logic [31:0] ia, da, wd;
      mask = int'($urandom_range(1, 3));
      mem_wait_cfg = int'($urandom_range(0, 3));
      ia = 32'($urandom_range(0, 7)) << 2;
      da = 32'($urandom_range(0, 7)) << 2;
      wd = $urandom;
      dwr = 1'($urandom_range(0, 1));
      if (mask == 3) begin
        first = (last == 0) ? 1 : 0;
        second = 1 - first;
        exp_seq.push_back(first);
        exp_seq.push_back(second);
      end else begin
        exp_seq.push_back((mask == 2) ? 1 : 0);
      end
      foreach (exp_seq[k]) begin
        if (exp_seq[k] == 0) exp_i_rdata = ref_rd(ia);
        else if (dwr) ref_arr[da] = wd;
        else exp_d_rdata = ref_rd(da);
        last = exp_seq[k];
      end
      if (mask[0]) begin
        bus.i_addr = ia;
        bus.i_req = 1'b1;
      end
      if (mask[1]) begin
        bus.d_addr = da;
        bus.d_wdata = wd;
        bus.d_write = dwr;
        bus.d_read = dwr ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      for (int c = 0; c < 40 && got.size() < exp_seq.size(); c++) begin
        tick();
        if (bus.err) err_total++;
        if (bus.i_done) begin
          got.push_back(0);
          bus.i_req = 1'b0;
        end
        if (bus.d_done) begin
          got.push_back(1);
          bus.d_read = 1'b0;
          bus.d_write = 1'b0;
        end
      end
      bad = (got.size() != exp_seq.size()) ? 1 : 0;
      for (int k = 0; k < got.size() && k < exp_seq.size(); k++)
        if (got[k] != exp_seq[k]) bad++;
      n_checks++;
      if (bad != 0)
        $display("FAIL rand_order r%0d: got %0d dones (%0d wrong) expected %0d",
                 r, got.size(), bad, exp_seq.size());
      else n_pass++;
      n_checks++;
      if (bus.i_rdata !== exp_i_rdata)
        $display("FAIL rand_irdata r%0d: got %h expected %h", r, bus.i_rdata, exp_i_rdata);
      else n_pass++;
      n_checks++;
      if (bus.d_rdata !== exp_d_rdata)
        $display("FAIL rand_drdata r%0d: got %h expected %h", r, bus.d_rdata, exp_d_rdata);
      else n_pass++;
      idle_inputs();
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    tick();
    n_checks++;
    if (err_total !== 0) $display("FAIL rand_err: got %0d expected 0", err_total);
    else n_pass++;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
